vip_cfg_arbiter: RTL and testbench

- Shares the single Avalon-MM write-only configuration port of the VIP cluster (scaler/mixer/CVO register space, 9-bit word address) between NREQ independent configuration masters.
- Requesters include the aspect/resolution configurator and a coefficient/gamma loader.
- Arbitration is round-robin with grant locking, so a requester's multi-register sequence (e.g. a "Valid=0 … Go" sequence) is never interleaved with another requester's writes.
- Sits between the config masters and the VIP slave, with a registered output stage and an idle-owner watchdog.

---
 rtl/vip_cfg_pkg.sv | 22 ++
 rtl/vip_rr_pick.sv | 35 +++
 rtl/vip_cfg_arbiter.sv | 149 ++++++++++++++
 tb/tb_vip_cfg_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vip_cfg_pkg.sv
// Shared definitions for the VIP configuration path: bus widths, slave bank
// decode and the arbiter state encoding.
package vip_cfg_pkg;

    localparam int VIP_CFG_AW = 9;
    localparam int VIP_CFG_DW = 32;

    // Slave bank select lives in address[8:7]
    localparam logic [1:0] VIP_BANK_SCALER = 2'd0;
    localparam logic [1:0] VIP_BANK_MIXER  = 2'd1;
    localparam logic [1:0] VIP_BANK_CVO    = 2'd2;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_t;

    function automatic logic [1:0] vip_bank(input logic [VIP_CFG_AW-1:0] addr);
        return addr[8:7];
    endfunction

endpackage

// File: rtl/vip_rr_pick.sv
// Combinational round-robin picker: first eligible requester searching upward
// from last+1 with wrap modulo N (N need not be a power of two).
module vip_rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] last,
    output logic          valid,
    output logic [PW-1:0] idx
);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, last} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            cand = sum[PW-1:0];
            if (!valid && req[cand] && eligible[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/vip_cfg_arbiter.sv
// Round-robin, grant-locked arbiter sharing the VIP write-only config port
// between NREQ masters, with a registered output slot and idle-owner watchdog.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  ARB_IDLE   | no owner; arbitrate among eligible requesters
//  ARB_OWNED  | owner holds the port until it drops s_req or the watchdog fires
module vip_cfg_arbiter
    import vip_cfg_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NREQ-1:0]            s_req,
    input  logic [VIP_CFG_AW*NREQ-1:0] s_address,
    input  logic [NREQ-1:0]            s_write,
    input  logic [VIP_CFG_DW*NREQ-1:0] s_writedata,
    output logic [NREQ-1:0]            s_waitrequest,
    output logic [NREQ-1:0]            s_grant,
    output logic [VIP_CFG_AW-1:0]      m_address,
    output logic                       m_write,
    output logic [VIP_CFG_DW-1:0]      m_writedata,
    input  logic                       m_waitrequest,
    output logic                       timeout_evt
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT) + 1;

    arb_state_t            state, state_nxt;
    logic [PW-1:0]         owner, owner_nxt;
    logic [PW-1:0]         last_owner, last_nxt;
    logic [CW-1:0]         idle_cnt, cnt_nxt;
    logic [NREQ-1:0]       blocked, blocked_nxt;
    logic                  m_write_nxt;
    logic [VIP_CFG_AW-1:0] m_address_nxt;
    logic [VIP_CFG_DW-1:0] m_writedata_nxt;
    logic                  tevt_nxt;

    logic                  pick_valid;
    logic [PW-1:0]         pick_idx;
    logic [VIP_CFG_AW-1:0] sel_addr;
    logic [VIP_CFG_DW-1:0] sel_data;
    logic                  own_req;
    logic                  own_write;
    logic                  slot_free;
    logic                  accept;

    vip_rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req      (s_req),
        .eligible (~blocked),
        .last     (last_owner),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_data  = '0;
        own_req   = 1'b0;
        own_write = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == PW'(i)) begin
                sel_addr  = s_address[i*VIP_CFG_AW +: VIP_CFG_AW];
                sel_data  = s_writedata[i*VIP_CFG_DW +: VIP_CFG_DW];
                own_req   = s_req[i];
                own_write = s_write[i];
            end
        end
    end

    // The slot can take a new write when empty or when its write completes now
    assign slot_free = ~m_write | ~m_waitrequest;
    assign accept    = (state == ARB_OWNED) & own_write & slot_free;

    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        last_nxt        = last_owner;
        cnt_nxt         = idle_cnt;
        tevt_nxt        = 1'b0;
        blocked_nxt     = blocked & s_req;
        m_write_nxt     = accept ? 1'b1 : (slot_free ? 1'b0 : m_write);
        m_address_nxt   = accept ? sel_addr : m_address;
        m_writedata_nxt = accept ? sel_data : m_writedata;
        s_grant         = '0;
        s_waitrequest   = '1;

        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_nxt = ARB_OWNED;
                    owner_nxt = pick_idx;
                    last_nxt  = pick_idx;
                    cnt_nxt   = '0;
                end
            end
            ARB_OWNED: begin
                s_grant[owner]       = 1'b1;
                s_waitrequest[owner] = ~slot_free;
                if (accept) begin
                    cnt_nxt = '0;
                end else if (slot_free) begin
                    // A release in the same cycle as the timeout wins
                    if (!own_req) begin
                        state_nxt = ARB_IDLE;
                    end else if (idle_cnt == CW'(TIMEOUT-1)) begin
                        state_nxt          = ARB_IDLE;
                        tevt_nxt           = 1'b1;
                        blocked_nxt[owner] = 1'b1;
                    end else begin
                        cnt_nxt = idle_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ARB_IDLE;
            owner       <= '0;
            last_owner  <= PW'(NREQ-1);
            idle_cnt    <= '0;
            blocked     <= '0;
            m_write     <= 1'b0;
            m_address   <= '0;
            m_writedata <= '0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last_owner  <= last_nxt;
            idle_cnt    <= cnt_nxt;
            blocked     <= blocked_nxt;
            m_write     <= m_write_nxt;
            m_address   <= m_address_nxt;
            m_writedata <= m_writedata_nxt;
            timeout_evt <= tevt_nxt;
        end
    end

endmodule

// File: tb/tb_vip_cfg_arbiter.sv
// Directed bench for vip_cfg_arbiter (NREQ=2, TIMEOUT=16): inputs change just
// after the rising edge, outputs are sampled on the falling edge.
module tb_vip_cfg_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  s_req = '0;
    logic [1:0]  s_write = '0;
    logic [8:0]  a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic [17:0] s_address;
    logic [63:0] s_writedata;
    logic [1:0]  s_waitrequest;
    logic [1:0]  s_grant;
    logic [8:0]  m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;
    logic        timeout_evt;

    int n_assert = 0;
    int n_fail   = 0;

    assign s_address   = {a1, a0};
    assign s_writedata = {d1, d0};

    always #5 clk = ~clk;

    vip_cfg_arbiter #(
        .NREQ    (2),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_req         (s_req),
        .s_address     (s_address),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_waitrequest (s_waitrequest),
        .s_grant       (s_grant),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .timeout_evt   (timeout_evt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset values
        probe();
        chk("rst_grant", 64'(s_grant), 64'h0);
        chk("rst_waitreq", 64'(s_waitrequest), 64'h3);
        chk("rst_mwrite", 64'(m_write), 64'h0);
        chk("rst_maddr", 64'(m_address), 64'h0);
        chk("rst_mdata", 64'(m_writedata), 64'h0);
        chk("rst_tevt", 64'(timeout_evt), 64'h0);
        tick();
        reset_n = 1'b1;

        // single requester, three back-to-back writes
        s_req = 2'b01;
        probe();
        chk("t1_lat_grant", 64'(s_grant), 64'h0);
        tick();
        s_write = 2'b01; a0 = 9'h004; d0 = 32'd0;
        probe();
        chk("t1_grant", 64'(s_grant), 64'h1);
        chk("t1_waitreq", 64'(s_waitrequest), 64'h2);
        tick();
        a0 = 9'h01E; d0 = 32'd1;
        probe();
        chk("t1_w0_wr", 64'(m_write), 64'h1);
        chk("t1_w0_addr", 64'(m_address), 64'h004);
        chk("t1_w0_data", 64'(m_writedata), 64'h0);
        tick();
        a0 = 9'h000; d0 = 32'd1;
        probe();
        chk("t1_w1_wr", 64'(m_write), 64'h1);
        chk("t1_w1_addr", 64'(m_address), 64'h01E);
        chk("t1_w1_data", 64'(m_writedata), 64'h1);
        tick();
        s_write = 2'b00; s_req = 2'b00;
        probe();
        chk("t1_w2_wr", 64'(m_write), 64'h1);
        chk("t1_w2_addr", 64'(m_address), 64'h000);
        chk("t1_w2_data", 64'(m_writedata), 64'h1);
        chk("t1_hold_grant", 64'(s_grant), 64'h1);
        tick();
        probe();
        chk("t1_rel_grant", 64'(s_grant), 64'h0);
        chk("t1_rel_wr", 64'(m_write), 64'h0);

        // contention straight out of reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        s_req = 2'b11;
        probe();
        chk("t2_idle", 64'(s_grant), 64'h0);
        tick();
        s_write = 2'b11; a0 = 9'h010; d0 = 32'hA; a1 = 9'h111; d1 = 32'hB;
        probe();
        chk("t2_grant0", 64'(s_grant), 64'h1);
        chk("t2_waitreq0", 64'(s_waitrequest), 64'h2);
        tick();
        s_req = 2'b10; s_write = 2'b10;
        probe();
        chk("t2_w0_addr", 64'(m_address), 64'h010);
        chk("t2_w0_data", 64'(m_writedata), 64'hA);
        chk("t2_waitreq1", 64'(s_waitrequest), 64'h2);
        tick();
        probe();
        chk("t2_gap_grant", 64'(s_grant), 64'h0);
        chk("t2_gap_wr", 64'(m_write), 64'h0);
        chk("t2_gap_waitreq", 64'(s_waitrequest), 64'h3);
        tick();
        probe();
        chk("t2_grant1", 64'(s_grant), 64'h2);
        chk("t2_waitreq_g1", 64'(s_waitrequest), 64'h1);
        tick();
        s_req = 2'b00; s_write = 2'b00;
        probe();
        chk("t2_w1_wr", 64'(m_write), 64'h1);
        chk("t2_w1_addr", 64'(m_address), 64'h111);
        chk("t2_w1_data", 64'(m_writedata), 64'hB);
        tick();
        probe();
        chk("t2_rel_grant", 64'(s_grant), 64'h0);

        // slave stall on the first write
        s_req = 2'b01;
        tick();
        s_write = 2'b01; a0 = 9'h083; d0 = 32'h280;
        probe();
        chk("t3_grant", 64'(s_grant), 64'h1);
        tick();
        m_waitrequest = 1'b1; a0 = 9'h084; d0 = 32'h281;
        for (int i = 0; i < 5; i++) begin
            probe();
            chk("t3_stall_wr", 64'(m_write), 64'h1);
            chk("t3_stall_addr", 64'(m_address), 64'h083);
            chk("t3_stall_data", 64'(m_writedata), 64'h280);
            chk("t3_stall_waitreq", 64'(s_waitrequest), 64'h3);
            tick();
        end
        m_waitrequest = 1'b0;
        probe();
        chk("t3_end_waitreq", 64'(s_waitrequest), 64'h2);
        chk("t3_end_addr", 64'(m_address), 64'h083);
        tick();
        s_write = 2'b00; s_req = 2'b00;
        probe();
        chk("t3_w2_wr", 64'(m_write), 64'h1);
        chk("t3_w2_addr", 64'(m_address), 64'h084);
        chk("t3_w2_data", 64'(m_writedata), 64'h281);
        tick();
        probe();
        chk("t3_rel_grant", 64'(s_grant), 64'h0);
        chk("t3_rel_wr", 64'(m_write), 64'h0);

        // watchdog: owner 1 never writes, owner 0 waiting
        s_req = 2'b11;
        tick();
        for (int n = 1; n <= 16; n++) begin
            probe();
            chk("t4_own_grant", 64'(s_grant), 64'h2);
            chk("t4_own_tevt", 64'(timeout_evt), 64'h0);
            tick();
        end
        probe();
        chk("t4_tevt", 64'(timeout_evt), 64'h1);
        chk("t4_revoked", 64'(s_grant), 64'h0);
        tick();
        s_req = 2'b10;
        probe();
        chk("t4_tevt_pulse", 64'(timeout_evt), 64'h0);
        chk("t4_grant0", 64'(s_grant), 64'h1);
        tick();
        probe();
        chk("t4_rel0", 64'(s_grant), 64'h0);
        for (int n = 0; n < 3; n++) begin
            tick();
            probe();
            chk("t4_blocked", 64'(s_grant), 64'h0);
        end
        tick();
        s_req = 2'b00;
        probe();
        tick();
        s_req = 2'b10;
        probe();
        chk("t4_unblock_idle", 64'(s_grant), 64'h0);
        tick();
        probe();
        chk("t4_regrant1", 64'(s_grant), 64'h2);

        // release coinciding with the last watchdog count
        for (int n = 0; n < 15; n++) begin
            tick();
        end
        s_req = 2'b00;
        probe();
        chk("t5_tie_grant", 64'(s_grant), 64'h2);
        chk("t5_tie_tevt", 64'(timeout_evt), 64'h0);
        tick();
        s_req = 2'b10;
        probe();
        chk("t5_no_tevt", 64'(timeout_evt), 64'h0);
        chk("t5_idle", 64'(s_grant), 64'h0);
        tick();
        probe();
        chk("t5_eligible", 64'(s_grant), 64'h2);
        tick();
        s_req = 2'b00;
        probe();
        tick();
        probe();
        chk("t5_rel", 64'(s_grant), 64'h0);

        // asynchronous reset in the middle of a stall
        tick();
        s_req = 2'b01;
        tick();
        s_write = 2'b01; a0 = 9'h155; d0 = 32'hDEADBEEF; m_waitrequest = 1'b1;
        tick();
        chk("t6_pre_wr", 64'(m_write), 64'h1);
        chk("t6_pre_addr", 64'(m_address), 64'h155);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_wr", 64'(m_write), 64'h0);
        chk("t6_rst_grant", 64'(s_grant), 64'h0);
        chk("t6_rst_waitreq", 64'(s_waitrequest), 64'h3);
        chk("t6_rst_addr", 64'(m_address), 64'h0);
        chk("t6_rst_data", 64'(m_writedata), 64'h0);
        s_req = 2'b00; s_write = 2'b00; m_waitrequest = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
